led_pwm_driver: RTL and testbench

Parametrised multi-channel LED driver, successor to the single-output fixed-rate blinker. Each channel drives one active-low LED pin with frame-synchronous PWM brightness and one of four modes (off, steady, blink, breathe). It sits directly between a configuration source (CPU register or test logic) and the board LED pins. All channels share one prescaler and PWM counter.

---
 rtl/led_pwm_pkg.sv | 14 +
 rtl/led_pwm_channel.sv | 111 +++++++++++
 rtl/led_pwm_driver.sv | 72 +++++++
 tb/tb_led_pwm_driver.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/led_pwm_pkg.sv
// Shared types for the multi-channel LED PWM driver.
// Channel modes and config field widths.
package led_pwm_pkg;

   typedef enum logic [1:0] {
      MODE_OFF     = 2'd0,
      MODE_ON      = 2'd1,
      MODE_BLINK   = 2'd2,
      MODE_BREATHE = 2'd3
   } led_mode_t;

   localparam int PERIOD_W = 16;

endpackage

// File: rtl/led_pwm_channel.sv
// One LED channel: pending/active config, blink/breathe stepping,
// PWM compare and the registered active-low pin drive.
module led_pwm_channel
   import led_pwm_pkg::*;
#(
   parameter int PWM_BITS = 8
)(
   input  logic                clk,
   input  logic                nRST,
   input  logic                wr,
   input  led_mode_t           wr_mode,
   input  logic [PWM_BITS-1:0] wr_duty,
   input  logic [PERIOD_W-1:0] wr_period,
   input  logic [PWM_BITS-1:0] pwm_cnt,
   input  logic                boundary,
   output logic                led_n
);

   led_mode_t           p_mode;
   led_mode_t           a_mode;
   logic [PWM_BITS-1:0] p_duty;
   logic [PWM_BITS-1:0] a_duty;
   logic [PERIOD_W-1:0] p_period;
   logic [PERIOD_W-1:0] a_period;
   logic [PERIOD_W-1:0] fcnt;
   logic [PWM_BITS-1:0] bre;
   logic [PWM_BITS-1:0] bre_nx;
   logic [PWM_BITS-1:0] level;
   logic                pend_valid;
   logic                phase;
   logic                dir_up;
   logic                dir_nx;

   // A write in the boundary cycle lands after the old pending is applied.
   always_ff @(posedge clk or negedge nRST) begin
      if (!nRST) begin
         p_mode     <= MODE_OFF;
         p_duty     <= '0;
         p_period   <= '0;
         pend_valid <= 1'b0;
      end else if (wr) begin
         p_mode     <= wr_mode;
         p_duty     <= wr_duty;
         p_period   <= wr_period;
         pend_valid <= 1'b1;
      end else if (boundary) begin
         pend_valid <= 1'b0;
      end
   end

   always_comb begin
      bre_nx = bre;
      dir_nx = dir_up;
      if (a_duty == '0) begin
         bre_nx = '0;
      end else if (dir_up) begin
         bre_nx = bre + 1'b1;
         if (bre_nx >= a_duty) dir_nx = 1'b0;
      end else begin
         bre_nx = bre - 1'b1;
         if (bre_nx == '0) dir_nx = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge nRST) begin
      if (!nRST) begin
         a_mode   <= MODE_OFF;
         a_duty   <= '0;
         a_period <= '0;
         fcnt     <= '0;
         phase    <= 1'b1;
         dir_up   <= 1'b1;
         bre      <= '0;
      end else if (boundary) begin
         if (pend_valid) begin
            a_mode   <= p_mode;
            a_duty   <= p_duty;
            a_period <= p_period;
            fcnt     <= '0;
            phase    <= 1'b1;
            dir_up   <= 1'b1;
            bre      <= '0;
         end else if (fcnt == a_period) begin
            fcnt <= '0;
            if (a_mode == MODE_BLINK) phase <= ~phase;
            if (a_mode == MODE_BREATHE) begin
               bre    <= bre_nx;
               dir_up <= dir_nx;
            end
         end else begin
            fcnt <= fcnt + 1'b1;
         end
      end
   end

   always_comb begin
      level = '0;
      unique case (a_mode)
         MODE_OFF:     level = '0;
         MODE_ON:      level = a_duty;
         MODE_BLINK:   level = phase ? a_duty : '0;
         MODE_BREATHE: level = bre;
      endcase
   end

   always_ff @(posedge clk or negedge nRST) begin
      if (!nRST) led_n <= 1'b1;
      else       led_n <= !(pwm_cnt < level);
   end

endmodule

// File: rtl/led_pwm_driver.sv
// Multi-channel LED driver: shared prescaler and PWM counter,
// frame boundary and write decode feeding per-channel engines.
module led_pwm_driver
   import led_pwm_pkg::*;
#(
   parameter int N_CH     = 3,
   parameter int PWM_BITS = 8,
   parameter int PRESCALE = 46,
   localparam int CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1
)(
   input  logic                clk,
   input  logic                nRST,
   input  logic                cfg_we,
   input  logic [CH_W-1:0]     cfg_ch,
   input  logic [1:0]          cfg_mode,
   input  logic [PWM_BITS-1:0] cfg_duty,
   input  logic [PERIOD_W-1:0] cfg_period,
   output logic [N_CH-1:0]     nLED,
   output logic                frame_start
);

   localparam int PRE_W = (PRESCALE > 0) ? $clog2(PRESCALE + 1) : 1;

   logic [PRE_W-1:0]    pre_cnt;
   logic [PWM_BITS-1:0] pwm_cnt;
   logic                tick;
   logic                boundary;
   logic                bnd_q;

   assign tick     = (pre_cnt == PRE_W'(PRESCALE));
   assign boundary = tick && (&pwm_cnt);

   always_ff @(posedge clk or negedge nRST) begin
      if (!nRST) begin
         pre_cnt <= '0;
         pwm_cnt <= '0;
      end else if (tick) begin
         pre_cnt <= '0;
         pwm_cnt <= pwm_cnt + 1'b1;
      end else begin
         pre_cnt <= pre_cnt + 1'b1;
      end
   end

   // Two stages so the pulse lines up with pwm_cnt==0 as seen on nLED.
   always_ff @(posedge clk or negedge nRST) begin
      if (!nRST) begin
         bnd_q       <= 1'b0;
         frame_start <= 1'b0;
      end else begin
         bnd_q       <= boundary;
         frame_start <= bnd_q;
      end
   end

   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      led_pwm_channel #(
         .PWM_BITS (PWM_BITS)
      ) u_ch (
         .clk       (clk),
         .nRST      (nRST),
         .wr        (cfg_we && (cfg_ch == CH_W'(i))),
         .wr_mode   (led_mode_t'(cfg_mode)),
         .wr_duty   (cfg_duty),
         .wr_period (cfg_period),
         .pwm_cnt   (pwm_cnt),
         .boundary  (boundary),
         .led_n     (nLED[i])
      );
   end

endmodule

// File: tb/tb_led_pwm_driver.sv
// Bench for led_pwm_driver: directed vector table, corner sequences
// and random config traffic against a frame-level reference model.
module tb_led_pwm_driver;

   localparam int NCH = 3;
   localparam int FR  = 16;

   logic        clk = 1'b0;
   logic        nRST = 1'b0;
   logic        cfg_we = 1'b0;
   logic [1:0]  cfg_ch = '0;
   logic [1:0]  cfg_mode = '0;
   logic [3:0]  cfg_duty = '0;
   logic [15:0] cfg_period = '0;
   logic [2:0]  nLED;
   logic        frame_start;

   int n_chk = 0;
   int n_fail = 0;

   // Reference model state: pending and active config per channel,
   // plus the frame index at which the active config took effect.
   int mcyc;
   int pv[NCH], pm[NCH], pd[NCH], pp[NCH];
   int am[NCH], ad[NCH], ap[NCH], af[NCH];
   logic [2:0] exp_led;
   logic       exp_fs;
   logic [2:0] s_led;
   logic       s_fs;
   int meas[NCH];

   led_pwm_driver #(
      .N_CH     (3),
      .PWM_BITS (4),
      .PRESCALE (0)
   ) dut (
      .clk         (clk),
      .nRST        (nRST),
      .cfg_we      (cfg_we),
      .cfg_ch      (cfg_ch),
      .cfg_mode    (cfg_mode),
      .cfg_duty    (cfg_duty),
      .cfg_period  (cfg_period),
      .nLED        (nLED),
      .frame_start (frame_start)
   );

   always #5 clk = ~clk;

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Level for a channel in a frame, from steps elapsed since apply.
   function automatic int model_level(input int c, input int f);
      int k, t, d;
      d = ad[c];
      k = (f - af[c]) / (ap[c] + 1);
      case (am[c])
         1: return d;
         2: return (k % 2 == 0) ? d : 0;
         3: begin
            if (d == 0) return 0;
            t = k % (2 * d);
            return (t <= d) ? t : 2 * d - t;
         end
         default: return 0;
      endcase
   endfunction

   task automatic model_reset();
      mcyc = 0;
      for (int c = 0; c < NCH; c++) begin
         pv[c] = 0; pm[c] = 0; pd[c] = 0; pp[c] = 0;
         am[c] = 0; ad[c] = 0; ap[c] = 0; af[c] = 0;
      end
   endtask

   task automatic model_step(input logic we, input int ch, input int mode,
                             input int duty, input int per);
      for (int c = 0; c < NCH; c++)
         exp_led[c] = !((mcyc % FR) < model_level(c, mcyc / FR));
      exp_fs = (mcyc % FR == 0) && (mcyc >= FR);
      if (mcyc % FR == FR - 1) begin
         for (int c = 0; c < NCH; c++) begin
            if (pv[c] != 0) begin
               am[c] = pm[c]; ad[c] = pd[c]; ap[c] = pp[c];
               af[c] = mcyc / FR + 1;
               pv[c] = 0;
            end
         end
      end
      if (we && ch < NCH) begin
         pv[ch] = 1; pm[ch] = mode; pd[ch] = duty; pp[ch] = per;
      end
      mcyc++;
   endtask

   // One clock: drive at negedge, predict, sample at next negedge.
   task automatic cyc(input logic we, input int ch, input int mode,
                      input int duty, input int per);
      cfg_we     = we;
      cfg_ch     = ch[1:0];
      cfg_mode   = mode[1:0];
      cfg_duty   = duty[3:0];
      cfg_period = per[15:0];
      model_step(we, ch, mode, duty, per);
      @(negedge clk);
      s_led = nLED;
      s_fs  = frame_start;
      check($sformatf("nLED cyc%0d", mcyc - 1), s_led, exp_led);
      check($sformatf("frame_start cyc%0d", mcyc - 1), s_fs, exp_fs);
      cfg_we = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, 0, 0, 0, 0);
   endtask

   task automatic do_reset();
      cfg_we = 1'b0;
      nRST = 1'b0;
      #1;
      check("reset nLED", nLED, 3'b111);
      check("reset frame_start", frame_start, 1'b0);
      @(negedge clk);
      @(negedge clk);
      nRST = 1'b1;
      model_reset();
   endtask

   // Count low cycles per channel over one nLED frame.
   task automatic measure();
      int w;
      w = 0;
      do begin
         idle(1);
         w++;
      end while (!s_fs && w < 40);
      if (!s_fs) begin
         n_chk++;
         n_fail++;
         $display("FAIL frame_start wait: none within %0d cycles", w);
      end
      for (int c = 0; c < NCH; c++) meas[c] = 0;
      for (int i = 0; i < FR; i++) begin
         if (i > 0) idle(1);
         for (int c = 0; c < NCH; c++) meas[c] += s_led[c] ? 0 : 1;
      end
   endtask

   typedef struct {
      int ch;
      int mode;
      int duty;
      int per;
      int nfr;
      int lit[9];
   } vec_t;

   vec_t tbl[6];

   initial begin
      tbl[0] = '{0, 1, 4, 0, 3, '{4, 4, 4, 0, 0, 0, 0, 0, 0}};
      tbl[1] = '{2, 2, 15, 1, 8, '{15, 15, 0, 0, 15, 15, 0, 0, 0}};
      tbl[2] = '{0, 3, 3, 0, 9, '{0, 1, 2, 3, 2, 1, 0, 1, 2}};
      tbl[3] = '{3, 1, 15, 0, 2, '{0, 0, 0, 0, 0, 0, 0, 0, 0}};
      tbl[4] = '{1, 1, 0, 0, 2, '{0, 0, 0, 0, 0, 0, 0, 0, 0}};
      tbl[5] = '{1, 1, 15, 0, 2, '{15, 15, 0, 0, 0, 0, 0, 0, 0}};

      @(negedge clk);
      for (int v = 0; v < 6; v++) begin
         do_reset();
         cyc(1'b1, tbl[v].ch, tbl[v].mode, tbl[v].duty, tbl[v].per);
         for (int f = 0; f < tbl[v].nfr; f++) begin
            measure();
            for (int c = 0; c < NCH; c++)
               check($sformatf("vec%0d ch%0d frame%0d lit", v, c, f),
                     meas[c], (c == tbl[v].ch) ? tbl[v].lit[f] : 0);
         end
      end

      // Last write wins, and a boundary-cycle write waits a frame.
      do_reset();
      cyc(1'b1, 1, 1, 2, 0);
      cyc(1'b1, 1, 1, 9, 0);
      measure();
      check("order ch1 lit", meas[1], 9);
      while (mcyc % FR != FR - 1) idle(1);
      cyc(1'b1, 1, 1, 5, 0);
      measure();
      check("bnd write old frame", meas[1], 9);
      measure();
      check("bnd write new frame", meas[1], 5);

      // Mid-frame async reset drops active and pending config.
      do_reset();
      cyc(1'b1, 0, 1, 8, 0);
      idle(20);
      cyc(1'b1, 1, 1, 5, 0);
      idle(2);
      #2;
      nRST = 1'b0;
      #1;
      check("async reset nLED", nLED, 3'b111);
      check("async reset frame_start", frame_start, 1'b0);
      @(negedge clk);
      @(negedge clk);
      nRST = 1'b1;
      model_reset();
      for (int f = 0; f < 2; f++) begin
         measure();
         check($sformatf("post reset ch0 f%0d", f), meas[0], 0);
         check($sformatf("post reset ch1 f%0d", f), meas[1], 0);
      end

      // Random config traffic.
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 7) == 0)
            cyc(1'b1, $urandom_range(0, 3), $urandom_range(0, 3),
                $urandom_range(0, 15), $urandom_range(0, 2));
         else
            idle(1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
